// File: rtl/pipe_stage_skid.sv
// Pipeline-stage register with valid/ready handshake, two-entry skid buffer and
// synchronous flush. All outputs come straight from flops.
module pipe_stage_skid #(
   parameter int unsigned CTRL_W     = 5,
   parameter int unsigned DATA_W     = 133,
   parameter bit          CLEAR_DATA = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [DATA_W-1:0] out_data,
   output logic [1:0]        count
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } state_t;

   state_t            state, state_nxt;
   logic [CTRL_W-1:0] skid_ctrl;
   logic [DATA_W-1:0] skid_data;
   logic              push, pop, kill;
   logic              ld_main_in, ld_main_skid, ld_skid, clr_main;

   assign push = in_valid & in_ready;
   assign pop  = out_valid & out_ready;
   assign kill = rst | flush;

   always_comb begin
      state_nxt    = state;
      ld_main_in   = 1'b0;
      ld_main_skid = 1'b0;
      ld_skid      = 1'b0;
      clr_main     = 1'b0;
      case (state)
         EMPTY: begin
            if (push) begin
               state_nxt  = ONE;
               ld_main_in = 1'b1;
            end
         end
         ONE: begin
            if (push && pop) begin
               ld_main_in = 1'b1;
            end else if (push) begin
               state_nxt = FULL;
               ld_skid   = 1'b1;
            end else if (pop) begin
               state_nxt = EMPTY;
               clr_main  = 1'b1;
            end
         end
         FULL: begin
            if (pop) begin
               state_nxt    = ONE;
               ld_main_skid = 1'b1;
            end
         end
         default: state_nxt = EMPTY;
      endcase
   end

   // Handshake flags are re-derived from the next state so they stay flop outputs.
   always_ff @(posedge clk) begin
      if (kill) begin
         state     <= EMPTY;
         out_valid <= 1'b0;
         in_ready  <= 1'b1;
         count     <= 2'd0;
      end else begin
         state     <= state_nxt;
         out_valid <= (state_nxt != EMPTY);
         in_ready  <= (state_nxt != FULL);
         count     <= 2'(state_nxt);
      end
   end

   always_ff @(posedge clk) begin
      if (kill) begin
         out_ctrl  <= '0;
         skid_ctrl <= '0;
      end else begin
         if (ld_main_in)        out_ctrl <= in_ctrl;
         else if (ld_main_skid) out_ctrl <= skid_ctrl;
         else if (clr_main)     out_ctrl <= '0;
         if (ld_skid)           skid_ctrl <= in_ctrl;
         else if (ld_main_skid) skid_ctrl <= '0;
      end
   end

   always_ff @(posedge clk) begin
      if (kill) begin
         if (CLEAR_DATA) begin
            out_data  <= '0;
            skid_data <= '0;
         end
      end else begin
         if (ld_main_in)        out_data <= in_data;
         else if (ld_main_skid) out_data <= skid_data;
         if (ld_skid)           skid_data <= in_data;
      end
   end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed and randomized checks of pipe_stage_skid: reset, streaming, back-pressure,
// flush behaviour and FIFO ordering against a queue scoreboard.
module tb_pipe_stage_skid;
   localparam int unsigned CTRL_W = 5;
   localparam int unsigned DATA_W = 133;
   localparam int unsigned N_RAND = 400;

   logic              clk = 1'b0;
   logic              rst, flush, in_valid, in_ready, out_valid, out_ready;
   logic [CTRL_W-1:0] in_ctrl, out_ctrl;
   logic [DATA_W-1:0] in_data, out_data;
   logic [1:0]        count;

   int errors = 0;
   int checks = 0;

   pipe_stage_skid #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .CLEAR_DATA(1'b1)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data),
      .count(count)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [DATA_W-1:0] mk_data(input int unsigned tag);
      logic [159:0] w;
      w = {$urandom, $urandom, $urandom, $urandom, 32'(tag)};
      return w[DATA_W-1:0];
   endfunction

   logic [DATA_W-1:0]        da, db;
   logic [CTRL_W+DATA_W-1:0] q[$];
   logic [CTRL_W+DATA_W-1:0] head;
   logic                     ir0;
   int unsigned              sent, recv, cyc;

   initial begin
      // reset with active inputs
      rst = 1'b1; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
      in_ctrl = 5'h1f; in_data = mk_data(99);
      tick(); tick();
      chk("rst_out_valid", out_valid, 0);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_count", count, 0);
      chk("rst_out_ctrl", out_ctrl, 0);
      chk("rst_out_data", out_data, 0);
      rst = 1'b0; in_valid = 1'b0;
      tick();
      chk("idle_out_valid", out_valid, 0);

      // streaming, one entry per cycle with 1-cycle latency
      for (int i = 1; i <= 8; i++) begin
         in_valid = 1'b1; in_ctrl = CTRL_W'(i); da = mk_data(i); in_data = da;
         tick();
         chk("stream_valid", out_valid, 1);
         chk("stream_ctrl", out_ctrl, i);
         chk("stream_data", out_data, da);
         chk("stream_count", count, 1);
         chk("stream_ready", in_ready, 1);
      end
      in_valid = 1'b0;
      tick();
      chk("drain_valid", out_valid, 0);
      chk("drain_ctrl", out_ctrl, 0);
      chk("drain_count", count, 0);

      // back-pressure: A then B with downstream stalled
      out_ready = 1'b0;
      in_valid = 1'b1; in_ctrl = 5'h0a; da = mk_data(10); in_data = da;
      tick();
      chk("bp_a_ctrl", out_ctrl, 5'h0a);
      chk("bp_a_count", count, 1);
      in_ctrl = 5'h0b; db = mk_data(11); in_data = db;
      tick();
      chk("bp_full_count", count, 2);
      chk("bp_full_ready", in_ready, 0);
      chk("bp_full_ctrl", out_ctrl, 5'h0a);
      chk("bp_full_data", out_data, da);
      in_valid = 1'b0;
      tick();
      chk("bp_hold_ctrl", out_ctrl, 5'h0a);
      chk("bp_hold_data", out_data, da);
      chk("bp_hold_count", count, 2);
      out_ready = 1'b1;
      tick();
      chk("bp_b_ctrl", out_ctrl, 5'h0b);
      chk("bp_b_data", out_data, db);
      chk("bp_b_count", count, 1);
      chk("bp_b_ready", in_ready, 1);
      tick();
      chk("bp_empty_valid", out_valid, 0);
      chk("bp_empty_count", count, 0);

      // flush while FULL with a coincident push of C
      out_ready = 1'b0; in_valid = 1'b1;
      in_ctrl = 5'h0a; in_data = mk_data(20); tick();
      in_ctrl = 5'h0b; in_data = mk_data(21); tick();
      chk("fl_pre_count", count, 2);
      in_ctrl = 5'h0c; in_data = mk_data(22); flush = 1'b1;
      tick();
      chk("fl_valid", out_valid, 0);
      chk("fl_ctrl", out_ctrl, 0);
      chk("fl_data", out_data, 0);
      chk("fl_count", count, 0);
      chk("fl_ready", in_ready, 1);
      flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      tick();
      chk("fl_c_dropped", out_valid, 0);
      tick();
      chk("fl_c_dropped2", out_valid, 0);

      // flush coincident with a pop of A
      in_valid = 1'b1; in_ctrl = 5'h0a; da = mk_data(30); in_data = da;
      tick();
      in_valid = 1'b0; flush = 1'b1; out_ready = 1'b1;
      chk("flpop_deliver_valid", out_valid, 1);
      chk("flpop_deliver_ctrl", out_ctrl, 5'h0a);
      chk("flpop_deliver_data", out_data, da);
      tick();
      flush = 1'b0;
      chk("flpop_empty_valid", out_valid, 0);
      chk("flpop_empty_count", count, 0);
      tick();
      chk("flpop_no_dup", out_valid, 0);

      // randomized valid/ready against a queue scoreboard
      q.delete(); sent = 0; recv = 0; cyc = 0;
      while ((sent < N_RAND || q.size() != 0) && cyc < 4000) begin
         cyc++;
         in_valid = (sent < N_RAND) && ($urandom_range(0, 1) == 1);
         in_ctrl  = CTRL_W'((sent % 31) + 1);
         in_data  = mk_data(sent);
         out_ready = 1'b0;
         #1 ir0 = in_ready;
         out_ready = ($urandom_range(0, 1) == 1);
         #1 chk("rnd_ready_comb", in_ready, ir0);
         chk("rnd_count", count, q.size());
         chk("rnd_ready", in_ready, q.size() != 2);
         chk("rnd_valid", out_valid, q.size() != 0);
         if (q.size() == 0) chk("rnd_bubble_ctrl", out_ctrl, 0);
         if (out_valid && out_ready && q.size() != 0) begin
            head = q.pop_front();
            chk("rnd_ctrl", out_ctrl, head[CTRL_W+DATA_W-1:DATA_W]);
            chk("rnd_data", out_data, head[DATA_W-1:0]);
            recv++;
         end
         if (in_valid && in_ready) begin
            q.push_back({in_ctrl, in_data});
            sent++;
         end
         tick();
      end
      chk("rnd_received", recv, N_RAND);
      chk("rnd_drained", q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
